scoreboard: RTL

- Per-register scoreboard sitting directly upstream of the hazard detector; it produces the pending bit, row and writeback-slot column that the detector consumes.
- Tracks, for each of NUM_REGS architectural registers, whether a write is outstanding (pending) and a shift-register row giving the cycles until a fixed-latency writeback.
- Updated by the issue stage when an instruction issues and by writeback when a result commits.
- Provides five combinational lookup ports (issue a/b, decode a/b, decode WAW) plus the structural-hazard column.

---
 rtl/scoreboard.sv | 133 +++++++++++++
 1 files changed

// File: rtl/scoreboard.sv
// Per-register pending/writeback-row scoreboard feeding the hazard detector.
// Five combinational lookup ports plus a writeback-slot occupancy column.
module scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int DEPTH    = 5
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                iss_set_en,
    input  logic [4:0]          iss_set_reg,
    input  logic [2:0]          iss_set_lat,
    input  logic                wb_en,
    input  logic [4:0]          wb_reg,
    input  logic [4:0]          iss_rd_reg_a,
    input  logic [4:0]          iss_rd_reg_b,
    input  logic [4:0]          id_rd_reg_a,
    input  logic [4:0]          id_rd_reg_b,
    input  logic [4:0]          id_waw_reg,
    input  logic [2:0]          iss_query_lat,
    output logic                iss_ass_pending_a,
    output logic                iss_ass_pending_b,
    output logic [DEPTH-1:0]    iss_ass_row_a,
    output logic [DEPTH-1:0]    iss_ass_row_b,
    output logic                id_ass_pending_a,
    output logic                id_ass_pending_b,
    output logic                id_ass_waw_write_pending,
    output logic [DEPTH-1:0]    id_ass_row_a,
    output logic [DEPTH-1:0]    id_ass_row_b,
    output logic [DEPTH-1:0]    id_ass_waw_write_row,
    output logic [NUM_REGS-1:0] sb_haz_column,
    output logic [5:0]          sb_pending_count
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic [DEPTH-1:0]    row [NUM_REGS];

    logic             set_ok;
    logic             clr_ok;
    logic             inc;
    logic             dec;
    logic [2:0]       lat_eff;
    logic [DEPTH-1:0] set_mask;
    logic [5:0]       count_next;

    assign set_ok = iss_set_en && (iss_set_reg != 5'd0);

    // A clear that collides with a set of the same register loses.
    assign clr_ok = wb_en && (wb_reg != 5'd0) && pending[wb_reg]
                 && !(set_ok && (iss_set_reg == wb_reg));

    assign inc = set_ok && !pending[iss_set_reg];
    assign dec = clr_ok;

    always_comb begin
        lat_eff = iss_set_lat;
        if (iss_set_lat > 3'(DEPTH)) begin
            lat_eff = 3'(DEPTH);
        end
    end

    always_comb begin
        set_mask = '0;
        if (lat_eff != 3'd0) begin
            set_mask = DEPTH'(1) << (lat_eff - 3'd1);
        end
    end

    always_comb begin
        pending_next = pending;
        if (wb_en && (wb_reg != 5'd0)) begin
            pending_next[wb_reg] = 1'b0;
        end
        if (set_ok) begin
            pending_next[iss_set_reg] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_comb begin
        count_next = sb_pending_count;
        if (inc && !dec && (sb_pending_count != 6'(NUM_REGS - 1))) begin
            count_next = sb_pending_count + 6'd1;
        end else if (dec && !inc && (sb_pending_count != 6'd0)) begin
            count_next = sb_pending_count - 6'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending          <= '0;
            sb_pending_count <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                row[r] <= '0;
            end
        end else begin
            pending          <= pending_next;
            sb_pending_count <= count_next;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (set_ok && (iss_set_reg == 5'(r))) begin
                    row[r] <= (row[r] >> 1) | set_mask;
                end else begin
                    row[r] <= row[r] >> 1;
                end
            end
        end
    end

    assign iss_ass_pending_a = (iss_rd_reg_a != 5'd0) && pending[iss_rd_reg_a];
    assign iss_ass_pending_b = (iss_rd_reg_b != 5'd0) && pending[iss_rd_reg_b];
    assign id_ass_pending_a  = (id_rd_reg_a != 5'd0) && pending[id_rd_reg_a];
    assign id_ass_pending_b  = (id_rd_reg_b != 5'd0) && pending[id_rd_reg_b];
    assign id_ass_waw_write_pending =
        (id_waw_reg != 5'd0) && pending[id_waw_reg];

    assign iss_ass_row_a = (iss_rd_reg_a != 5'd0) ? row[iss_rd_reg_a] : '0;
    assign iss_ass_row_b = (iss_rd_reg_b != 5'd0) ? row[iss_rd_reg_b] : '0;
    assign id_ass_row_a  = (id_rd_reg_a != 5'd0) ? row[id_rd_reg_a] : '0;
    assign id_ass_row_b  = (id_rd_reg_b != 5'd0) ? row[id_rd_reg_b] : '0;
    assign id_ass_waw_write_row =
        (id_waw_reg != 5'd0) ? row[id_waw_reg] : '0;

    // Existing writeback already occupying the slot the issuing op targets.
    always_comb begin
        sb_haz_column = '0;
        if ((iss_query_lat != 3'd0) && (int'(iss_query_lat) <= DEPTH - 1)) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                sb_haz_column[r] = |(row[r] & (DEPTH'(1) << iss_query_lat));
            end
        end
    end

endmodule
